// File: rtl/ad7608_emulator_pkg.sv
// ad7608_emulator_pkg
// Shared constants for the AD7608 pin-level emulator: default geometry
// (mirrors parameters.vh), FSM state encodings and the oversampling clamp.
// No ports.
package ad7608_emulator_pkg;

    localparam int DEF_W_DATA = 18;
    localparam int DEF_N_CHAN = 8;
    localparam int DEF_W_OS   = 3;
    localparam int DEF_T_CONV = 70;

    // Largest oversampling exponent the real part supports (ratio 64).
    localparam int unsigned MAX_OS = 6;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE    = 1'b0;
    localparam state_t ST_CONVERT = 1'b1;

    // Reserved OS codes behave like "no oversampling".
    function automatic int unsigned os_shift(input int unsigned os);
        return (os > MAX_OS) ? 0 : os;
    endfunction

endpackage

// File: rtl/ad7608_emulator_if.sv
// ad7608_emulator_if
// ADC pin bundle between adc_controller (master) and the emulator (slave).
//   adc_convst_in  : conversion start, master -> slave
//   adc_reset_in   : device reset, active high, master -> slave
//   adc_sclk_in    : serial clock, master -> slave
//   adc_n_cs_in    : chip select, active low, master -> slave
//   adc_busy_out   : conversion in progress, slave -> master
//   adc_data_a_out : serial data, first half of channels, slave -> master
//   adc_data_b_out : serial data, second half of channels, slave -> master
interface ad7608_emulator_if;
    import ad7608_emulator_pkg::*;

    logic adc_convst_in;
    logic adc_reset_in;
    logic adc_sclk_in;
    logic adc_n_cs_in;
    logic adc_busy_out;
    logic adc_data_a_out;
    logic adc_data_b_out;

    modport master (
        output adc_convst_in, adc_reset_in, adc_sclk_in, adc_n_cs_in,
        input  adc_busy_out, adc_data_a_out, adc_data_b_out
    );

    modport slave (
        input  adc_convst_in, adc_reset_in, adc_sclk_in, adc_n_cs_in,
        output adc_busy_out, adc_data_a_out, adc_data_b_out
    );

endinterface

// File: rtl/ad7608_emulator_sync_edge.sv
// sync_edge
// Two-flop synchronizer for an asynchronous pin followed by a registered
// edge detector.
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset
//   d_i     : asynchronous input pin
//   level_o : synchronized level (2 cycles of latency)
//   rise_o  : one-cycle pulse on a synchronized rising edge (3 cycles)
//   fall_o  : one-cycle pulse on a synchronized falling edge (3 cycles)
module sync_edge
    import ad7608_emulator_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ad7608_emulator.sv
// ad7608_emulator
// Pin-level responder for the AD7608 serial protocol. Snapshots a parallel
// vector of channel samples on CONVST, holds BUSY for the conversion time
// scaled by the oversampling ratio, then commits the snapshot to a shadow
// register that the serial readout shifts out MSB first.
//   clk_in        : system clock, at least 8x SCLK
//   n_rst_in      : asynchronous active-low reset
//   chan_data_in  : N_CHAN samples of W_DATA bits, ch0 in the LSBs
//   adc_os_in     : oversampling select, ratio 2^os (codes > 6 act as 0)
//   adc           : ADC pin bundle (slave side)
//   conv_done_out : one-cycle pulse when a result is committed
module ad7608_emulator
    import ad7608_emulator_pkg::*;
#(
    parameter int W_DATA = DEF_W_DATA,
    parameter int N_CHAN = DEF_N_CHAN,
    parameter int W_OS   = DEF_W_OS,
    parameter int T_CONV = DEF_T_CONV
) (
    input  logic                     clk_in,
    input  logic                     n_rst_in,
    input  logic [N_CHAN*W_DATA-1:0] chan_data_in,
    input  logic [W_OS-1:0]          adc_os_in,
    ad7608_emulator_if.slave         adc,
    output logic                     conv_done_out
);

    localparam int N_HALF = N_CHAN / 2;
    localparam int HALF_W = N_HALF * W_DATA;
    localparam int CNT_W  = $clog2((T_CONV << MAX_OS) + 1);
    localparam logic [CNT_W-1:0] T_CONV_C = CNT_W'(T_CONV);

    logic convst_lvl, convst_rise, convst_fall;
    logic reset_lvl,  reset_rise,  reset_fall;
    logic sclk_lvl,   sclk_rise,   sclk_fall;
    logic ncs_lvl,    ncs_rise,    ncs_fall;

    sync_edge u_sync_convst (
        .clk_i  (clk_in),
        .rst_n_i(n_rst_in),
        .d_i    (adc.adc_convst_in),
        .level_o(convst_lvl),
        .rise_o (convst_rise),
        .fall_o (convst_fall)
    );

    sync_edge u_sync_reset (
        .clk_i  (clk_in),
        .rst_n_i(n_rst_in),
        .d_i    (adc.adc_reset_in),
        .level_o(reset_lvl),
        .rise_o (reset_rise),
        .fall_o (reset_fall)
    );

    sync_edge u_sync_sclk (
        .clk_i  (clk_in),
        .rst_n_i(n_rst_in),
        .d_i    (adc.adc_sclk_in),
        .level_o(sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge u_sync_ncs (
        .clk_i  (clk_in),
        .rst_n_i(n_rst_in),
        .d_i    (adc.adc_n_cs_in),
        .level_o(ncs_lvl),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    // Edge/level outputs this block has no use for.
    logic unused_edges;
    assign unused_edges = ^{convst_lvl, convst_fall, reset_rise, reset_fall,
                            sclk_lvl, sclk_rise, ncs_rise};

    // Each half of the shadow register holds its channels ascending from the
    // LSB; the serial stream wants the lowest channel first, so reverse the
    // channel order (bits within a channel stay MSB-high).
    function automatic logic [HALF_W-1:0] msb_first(input logic [HALF_W-1:0] chans);
        logic [HALF_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_HALF; i++) begin
            r[(N_HALF-1-i)*W_DATA +: W_DATA] = chans[i*W_DATA +: W_DATA];
        end
        return r;
    endfunction

    state_t                    state_q,  state_d;
    logic [CNT_W-1:0]          cnt_q,    cnt_d;
    logic [N_CHAN*W_DATA-1:0]  sample_q, sample_d;
    logic [N_CHAN*W_DATA-1:0]  shadow_q, shadow_d;
    logic                      done_q,   done_d;
    logic [HALF_W-1:0]         sh_a_q,   sh_a_d;
    logic [HALF_W-1:0]         sh_b_q,   sh_b_d;

    // Conversion FSM. Synced RESET dominates everything, including a CONVST
    // edge arriving in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;

        if (reset_lvl) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            sample_d = '0;
            shadow_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (convst_rise) begin
                        state_d  = ST_CONVERT;
                        cnt_d    = T_CONV_C << os_shift(32'(adc_os_in));
                        sample_d = chan_data_in;
                    end
                end
                default: begin
                    // Counter holds the remaining BUSY cycles including the
                    // current one, so the last busy cycle sees 1.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        shadow_d = sample_q;
                        done_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Serial readout. The shift registers act as the bit pointer: shifting
    // zeros in from the bottom makes the stream run out to 0 once all
    // channels have been sent.
    always_comb begin
        sh_a_d = sh_a_q;
        sh_b_d = sh_b_q;

        if (ncs_lvl) begin
            sh_a_d = '0;
            sh_b_d = '0;
        end else if (ncs_fall) begin
            sh_a_d = msb_first(shadow_q[HALF_W-1:0]);
            sh_b_d = msb_first(shadow_q[2*HALF_W-1:HALF_W]);
        end else if (sclk_fall) begin
            sh_a_d = {sh_a_q[HALF_W-2:0], 1'b0};
            sh_b_d = {sh_b_q[HALF_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
        end
    end

    assign adc.adc_busy_out   = (state_q == ST_CONVERT);
    assign adc.adc_data_a_out = sh_a_q[HALF_W-1];
    assign adc.adc_data_b_out = sh_b_q[HALF_W-1];
    assign conv_done_out      = done_q;

endmodule

// File: tb/tb_ad7608_emulator.sv
// tb_ad7608_emulator
// Self-checking bench for ad7608_emulator: reset state, a table of
// conversion/readout vectors, hand-written corner sequences and randomized
// conversions compared against a bit-stream reference model.
module tb_ad7608_emulator;

    localparam int W  = 18;
    localparam int N  = 8;
    localparam int T  = 70;
    localparam int DW = N * W;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [DW-1:0] chan;
    logic [2:0]    os;
    logic          conv_done;

    ad7608_emulator_if adc_bus();

    ad7608_emulator #(
        .W_DATA(W),
        .N_CHAN(N),
        .W_OS  (3),
        .T_CONV(T)
    ) dut (
        .clk_in       (clk),
        .n_rst_in     (n_rst),
        .chan_data_in (chan),
        .adc_os_in    (os),
        .adc          (adc_bus),
        .conv_done_out(conv_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: the last committed conversion result.
    logic [DW-1:0] model_shadow;

    typedef struct {
        logic [2:0]    os;
        logic [DW-1:0] data;
        int            exp_len;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Expected serial stream: element i is the bit seen at the i-th SCLK
    // rising edge. Line A carries ch 0..3, line B ch 4..7, MSB first.
    function automatic logic [0:79] exp_stream(input logic [DW-1:0] v, input bit line_b,
                                               input int nbits);
        logic [0:79] r;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 4 * W) begin
                int ch;
                int bt;
                ch   = i / W + (line_b ? 4 : 0);
                bt   = W - 1 - (i % W);
                r[i] = v[ch*W + bt];
            end
        end
        return r;
    endfunction

    function automatic int exp_busy(input logic [2:0] o);
        return T << ((o > 3'd6) ? 0 : int'(o));
    endfunction

    // Reads nbits over one nCS window, sampling each bit just before the
    // SCLK rising edge. idle_ok reports both lines at 0 after nCS rises.
    task automatic do_read(input int nbits, output logic [0:79] ra, output logic [0:79] rb,
                           output logic idle_ok);
        ra = '0;
        rb = '0;
        @(negedge clk);
        adc_bus.adc_n_cs_in = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ra[i] = adc_bus.adc_data_a_out;
            rb[i] = adc_bus.adc_data_b_out;
            adc_bus.adc_sclk_in = 1'b1;
            repeat (4) @(negedge clk);
            adc_bus.adc_sclk_in = 1'b0;
            repeat (5) @(negedge clk);
        end
        adc_bus.adc_n_cs_in = 1'b1;
        repeat (4) @(negedge clk);
        idle_ok = (adc_bus.adc_data_a_out == 1'b0) && (adc_bus.adc_data_b_out == 1'b0);
    endtask

    // Runs one conversion and measures it. mode 1: second CONVST pulse 10
    // cycles into BUSY. mode 2: RESET pin raised 20 cycles into BUSY.
    task automatic run_conv(input logic [2:0] o, input logic [DW-1:0] d, input int mode,
                            output int lat, output int blen, output int ndone,
                            output logic done_ok, output int fall_after);
        bit started;
        bit finished;
        int post;
        int rst_at;
        started    = 1'b0;
        finished   = 1'b0;
        post       = 0;
        rst_at     = -1;
        lat        = 0;
        blen       = 0;
        ndone      = 0;
        done_ok    = 1'b0;
        fall_after = 0;
        os   = o;
        chan = d;
        adc_bus.adc_convst_in = 1'b1;
        for (int i = 1; i < 6000 && post < 8; i++) begin
            @(negedge clk);
            if (i == 3) adc_bus.adc_convst_in = 1'b0;
            if (conv_done) ndone++;
            if (!finished) begin
                if (adc_bus.adc_busy_out) begin
                    if (!started) begin
                        started = 1'b1;
                        lat     = i;
                    end
                    blen++;
                    if (mode == 1 && blen == 10) adc_bus.adc_convst_in = 1'b1;
                    if (mode == 1 && blen == 13) adc_bus.adc_convst_in = 1'b0;
                    if (mode == 2 && blen == 20) begin
                        adc_bus.adc_reset_in = 1'b1;
                        rst_at = i;
                    end
                end else if (started) begin
                    finished = 1'b1;
                    done_ok  = conv_done;
                    if (rst_at >= 0) fall_after = i - rst_at;
                end
            end else begin
                post++;
            end
            if (rst_at >= 0 && i == rst_at + 6) adc_bus.adc_reset_in = 1'b0;
        end
        adc_bus.adc_convst_in = 1'b0;
        adc_bus.adc_reset_in  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    int          lat, blen, ndone, fall_after;
    int          lat2, blen2, ndone2, fall2;
    logic        done_ok, done_ok2, idle_ok;
    logic [0:79] ra, rb;
    logic [DW-1:0] d;
    logic [2:0]  ro;

    initial begin
        n_rst = 1'b0;
        chan  = '0;
        os    = '0;
        adc_bus.adc_convst_in = 1'b0;
        adc_bus.adc_reset_in  = 1'b0;
        adc_bus.adc_sclk_in   = 1'b0;
        adc_bus.adc_n_cs_in   = 1'b1;
        model_shadow = '0;

        tbl[0] = '{3'd0, {18'h00444, 18'h00333, 18'h00222, 18'h15555,
                          18'h00004, 18'h00003, 18'h00002, 18'h2AAAA}, 70};
        tbl[1] = '{3'd3, rand_data(), 560};
        tbl[2] = '{3'd7, rand_data(), 70};
        tbl[3] = '{3'd1, rand_data(), 140};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",   80'(adc_bus.adc_busy_out),   80'(0));
        chk("rst_data_a", 80'(adc_bus.adc_data_a_out), 80'(0));
        chk("rst_data_b", 80'(adc_bus.adc_data_b_out), 80'(0));
        chk("rst_done",   80'(conv_done),              80'(0));
        n_rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_data_a", 80'(adc_bus.adc_data_a_out), 80'(0));

        // Table-driven conversions and readouts
        for (int v = 0; v < 4; v++) begin
            run_conv(tbl[v].os, tbl[v].data, 0, lat, blen, ndone, done_ok, fall_after);
            model_shadow = tbl[v].data;
            chk($sformatf("tbl%0d_latency", v), 80'(lat),     80'(4));
            chk($sformatf("tbl%0d_busy",    v), 80'(blen),    80'(tbl[v].exp_len));
            chk($sformatf("tbl%0d_ndone",   v), 80'(ndone),   80'(1));
            chk($sformatf("tbl%0d_donefall", v), 80'(done_ok), 80'(1));
            do_read(72, ra, rb, idle_ok);
            chk($sformatf("tbl%0d_read_a", v), 80'(ra), 80'(exp_stream(model_shadow, 1'b0, 72)));
            chk($sformatf("tbl%0d_read_b", v), 80'(rb), 80'(exp_stream(model_shadow, 1'b1, 72)));
            chk($sformatf("tbl%0d_idle", v), 80'(idle_ok), 80'(1));
            if (v == 0) begin
                chk("a_first18", 80'(ra[0:17]), 80'(18'h2AAAA));
                chk("b_first18", 80'(rb[0:17]), 80'(18'h15555));
            end
        end

        // Second CONVST during BUSY is ignored
        d = rand_data();
        run_conv(3'd0, d, 1, lat, blen, ndone, done_ok, fall_after);
        model_shadow = d;
        chk("reconv_busy",  80'(blen),  80'(70));
        chk("reconv_ndone", 80'(ndone), 80'(1));

        // Read during a conversion returns the previous result
        fork
            run_conv(3'd4, '0, 0, lat2, blen2, ndone2, done_ok2, fall2);
            begin
                repeat (8) @(negedge clk);
                do_read(72, ra, rb, idle_ok);
            end
        join
        chk("busyread_len", 80'(blen2), 80'(1120));
        chk("busyread_a", 80'(ra), 80'(exp_stream(model_shadow, 1'b0, 72)));
        chk("busyread_b", 80'(rb), 80'(exp_stream(model_shadow, 1'b1, 72)));
        model_shadow = '0;
        do_read(72, ra, rb, idle_ok);
        chk("after_zero_a", 80'(ra), 80'(0));
        chk("after_zero_b", 80'(rb), 80'(0));

        // Over-long frame and aborted frame
        d = rand_data();
        run_conv(3'd0, d, 0, lat, blen, ndone, done_ok, fall_after);
        model_shadow = d;
        do_read(80, ra, rb, idle_ok);
        chk("long_a", 80'(ra), 80'(exp_stream(model_shadow, 1'b0, 80)));
        chk("long_b", 80'(rb), 80'(exp_stream(model_shadow, 1'b1, 80)));
        chk("long_tail", 80'(ra[72:79]), 80'(0));
        do_read(9, ra, rb, idle_ok);
        chk("abort_a", 80'(ra), 80'(exp_stream(model_shadow, 1'b0, 9)));
        do_read(72, ra, rb, idle_ok);
        chk("restart_a", 80'(ra), 80'(exp_stream(model_shadow, 1'b0, 72)));
        chk("restart_b", 80'(rb), 80'(exp_stream(model_shadow, 1'b1, 72)));

        // RESET pin mid-BUSY
        run_conv(3'd2, rand_data(), 2, lat, blen, ndone, done_ok, fall_after);
        model_shadow = '0;
        chk("rstpin_ndone", 80'(ndone), 80'(0));
        chk("rstpin_fall", 80'(fall_after > 0 && fall_after <= 3), 80'(1));
        do_read(72, ra, rb, idle_ok);
        chk("rstpin_read_a", 80'(ra), 80'(0));
        chk("rstpin_read_b", 80'(rb), 80'(0));

        // n_rst_in asserted mid-read
        d = {18'h12345, 18'h0F0F0, 18'h00001, 18'h3FFFF,
             18'h2AAAA, 18'h11111, 18'h00FFF, 18'h3FFFF};
        run_conv(3'd0, d, 0, lat, blen, ndone, done_ok, fall_after);
        model_shadow = d;
        @(negedge clk);
        adc_bus.adc_n_cs_in = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            adc_bus.adc_sclk_in = 1'b1;
            repeat (4) @(negedge clk);
            adc_bus.adc_sclk_in = 1'b0;
            repeat (5) @(negedge clk);
        end
        ra = exp_stream(model_shadow, 1'b0, 6);
        rb = exp_stream(model_shadow, 1'b1, 6);
        chk("prerst_a", 80'(adc_bus.adc_data_a_out), 80'(ra[5]));
        chk("prerst_b", 80'(adc_bus.adc_data_b_out), 80'(rb[5]));
        n_rst = 1'b0;
        #1;
        chk("nrst_a",    80'(adc_bus.adc_data_a_out), 80'(0));
        chk("nrst_b",    80'(adc_bus.adc_data_b_out), 80'(0));
        chk("nrst_busy", 80'(adc_bus.adc_busy_out),   80'(0));
        @(negedge clk);
        adc_bus.adc_n_cs_in = 1'b1;
        n_rst = 1'b1;
        model_shadow = '0;
        repeat (4) @(negedge clk);
        do_read(72, ra, rb, idle_ok);
        chk("nrst_read_a", 80'(ra), 80'(0));

        // Randomized conversions against the reference model
        for (int r = 0; r < 6; r++) begin
            ro = 3'($urandom_range(0, 7));
            d  = rand_data();
            run_conv(ro, d, 0, lat, blen, ndone, done_ok, fall_after);
            model_shadow = d;
            chk($sformatf("rnd%0d_busy", r),  80'(blen),  80'(exp_busy(ro)));
            chk($sformatf("rnd%0d_ndone", r), 80'(ndone), 80'(1));
            do_read(72, ra, rb, idle_ok);
            chk($sformatf("rnd%0d_read_a", r), 80'(ra), 80'(exp_stream(model_shadow, 1'b0, 72)));
            chk($sformatf("rnd%0d_read_b", r), 80'(rb), 80'(exp_stream(model_shadow, 1'b1, 72)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
